ula_arbiter: RTL
================

# ula_arbiter

Two-port round-robin arbiter and sequencer that shares the single 8-bit ULA between two requesters (e.g. the main datapath and a branch/address unit). It registers the granted request's operands and operation, drives the ULA for one cycle, captures result and zero flag, and returns them on the granted port's response channel with a valid/ready handshake. It sits between the requesters and the ULA instance and is the only driver of the ULA inputs.

## Interface

- W, 8, data width of operands and result.

- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  request present on port n.
- req0_a / req1_a  in  W  operand A (SrcA).
- req0_b / req1_b  in  W  operand B (SrcB).
- req0_op / req1_op  in  3  ULA operation code.
- req0_ready / req1_ready  out  1  request accepted this cycle (valid && ready).
- rsp0_valid / rsp1_valid  out  1  response present on port n.
- rsp0_ready / rsp1_ready  in  1  requester takes response.
- rsp_result  out  W  result, shared by both response ports.
- rsp_zero  out  1  zero flag of result.
- rsp_err  out  1  request carried an illegal op code.
- ula_srca, ula_srcb  out  W  to ULA SrcA/SrcB.
- ula_control  out  3  to ULA ULAControl.
- ula_result  in  W  from ULA ULAResult.
- ula_flagz  in  1  from ULA flagZ.

## Operation

- Legal ops: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (unsigned, result 0x01/0x00). 011, 100, 101 illegal.
- FSM states IDLE, EXEC, RESP.
- IDLE: if neither valid, stay. If exactly one valid, grant it. If both valid, grant the port that is not last_grant. Grant asserts that port's reqN_ready combinationally (only in IDLE); operands, op, and grant index are latched; last_grant <= grant; go EXEC.
- EXEC: latched operands/op drive ula_srca/srcb/control. At end of cycle, ula_result → rsp_result, ula_flagz → rsp_zero, rsp_err <= 0. Illegal op: ULA output ignored, ula_control driven 010, rsp_result <= 0x00, rsp_zero <= 1, rsp_err <= 1. Go RESP.
- RESP: rspN_valid high for granted port only; the other rsp valid is 0. Response fields are held stable until rspN_ready. On handshake, go IDLE. No new request is accepted in RESP.
- Never both reqN_ready high, never both rspN_valid high.
- Reset values: state IDLE, last_grant = 1 (port 0 wins first tie), ula_srca = ula_srcb = 0x00, ula_control = 010, rsp_result = 0x00, rsp_zero = 0, rsp_err = 0, all ready/valid outputs 0.
- Reset mid-operation: in-flight request is discarded and no response is produced. Reset is also applied during RESP.
- Requester may drop valid without acceptance; no request is latched unless ready was high.

## Timing

- Accept at cycle T. EXEC is T+1, with ULA inputs stable for the whole cycle. rspN_valid first high at T+2.
- Response latency is 2 cycles. With rsp_ready already high, the next accept is earliest at T+3, giving 1 op per 3 cycles maximum.
- ULA is combinational. The path ula_* out → ULA → ula_result in must close within one cycle.
- ula_* outputs hold their last latched values outside EXEC. They change only on accept.

## Structure

- Shared package ula_pkg holds:
  - op localparams ULA_AND, ULA_OR, ULA_ADD, ULA_SUB, ULA_SLT;
  - state enum {IDLE, EXEC, RESP};
  - function ula_op_legal(op).
- The ULA instance and its opcode constants must use ula_pkg.
- One sub-module: ula_rr_pick. It is a combinational 2-way round-robin picker with inputs valid[1:0] and last and outputs gnt_valid and gnt_idx. It is reusable for future shared units.

## Test plan

- Single request: port 0 with a=0x0F, b=0xF0, op=001 accepted at T. rsp0_valid at T+2 with result 0xFF, zero 0, err 0. rsp1_valid stays 0.
- Zero flag: port 1 with a=0x55, b=0x55, op=110 gives result 0x00, zero 1. Then op=111 with a=0x03, b=0x07 gives 0x01, zero 0.
- Tie after reset: both valid (port 0 ADD 0x01+0x02, port 1 AND 0xFF&0x0F). Port 0 is granted first and returns 0x03. Port 1 is granted next and returns 0x0F. Continuous ties alternate 0,1,0,1.
- Backpressure: rsp0_ready held low 5 cycles with result 0x80 from 0x7F+0x01. rsp0_valid and result 0x80 stay stable the whole time. Pending req1 is not readied until the cycle after the handshake.
- Illegal op: op=100 with a=0x12, b=0x34 gives rsp_err 1, result 0x00, zero 1, and ula_control 010 during EXEC.
- Reset in EXEC: no rsp_valid ever appears for that request. All outputs return to reset values immediately (asynchronously). A fresh tie is then granted to port 0.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared ULA definitions: opcode constants, arbiter state encoding and opcode legality.
package ula_pkg;

    localparam logic [2:0] ULA_AND = 3'b000;
    localparam logic [2:0] ULA_OR  = 3'b001;
    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_SUB = 3'b110;
    localparam logic [2:0] ULA_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    function automatic logic ula_op_legal(input logic [2:0] op);
        logic legal_s;
        case (op)
            ULA_AND, ULA_OR, ULA_ADD, ULA_SUB, ULA_SLT: legal_s = 1'b1;
            default:                                    legal_s = 1'b0;
        endcase
        return legal_s;
    endfunction

endpackage

// File: rtl/ula_rr_pick.sv
// Combinational two-way round-robin picker; on a tie the port that did not win last time wins.
module ula_rr_pick (
    input  logic [1:0] valid,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // Grant selection
    always_comb begin
        gnt_valid = |valid;
        case (valid)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/ula_arbiter.sv
// Shares one combinational ULA between two requesters: accept, execute one cycle, respond.
module ula_arbiter
    import ula_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [2:0]   req0_op,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [2:0]   req1_op,
    output logic         req1_ready,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp_result,
    output logic         rsp_zero,
    output logic         rsp_err,
    output logic [W-1:0] ula_srca,
    output logic [W-1:0] ula_srcb,
    output logic [2:0]   ula_control,
    input  logic [W-1:0] ula_result,
    input  logic         ula_flagz
);

    state_t       state_r;
    state_t       state_s;
    logic         last_grant_r;
    logic         gidx_r;
    logic [W-1:0] srca_r;
    logic [W-1:0] srcb_r;
    logic [2:0]   ctrl_r;
    logic         illegal_r;
    logic [W-1:0] result_r;
    logic         zero_r;
    logic         err_r;

    logic         gnt_valid_s;
    logic         gnt_idx_s;
    logic         accept_s;
    logic         rsp_hs_s;
    logic [W-1:0] sel_a_s;
    logic [W-1:0] sel_b_s;
    logic [2:0]   sel_op_s;

    ula_rr_pick u_pick (
        .valid     ({req1_valid, req0_valid}),
        .last      (last_grant_r),
        .gnt_valid (gnt_valid_s),
        .gnt_idx   (gnt_idx_s)
    );

    assign sel_a_s  = gnt_idx_s ? req1_a  : req0_a;
    assign sel_b_s  = gnt_idx_s ? req1_b  : req0_b;
    assign sel_op_s = gnt_idx_s ? req1_op : req0_op;
    assign rsp_hs_s = (state_r == RESP) && (gidx_r ? rsp1_ready : rsp0_ready);

    // Ready is only ever offered from IDLE, and is held off while reset is asserted
    assign req0_ready = accept_s && !gnt_idx_s && !reset;
    assign req1_ready = accept_s &&  gnt_idx_s && !reset;
    assign rsp0_valid = (state_r == RESP) && !gidx_r;
    assign rsp1_valid = (state_r == RESP) &&  gidx_r;

    assign ula_srca    = srca_r;
    assign ula_srcb    = srcb_r;
    assign ula_control = ctrl_r;
    assign rsp_result  = result_r;
    assign rsp_zero    = zero_r;
    assign rsp_err     = err_r;

    // Next-state and accept decode
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (gnt_valid_s) begin
                    accept_s = 1'b1;
                    state_s  = EXEC;
                end else begin
                    state_s  = IDLE;
                end
            end
            EXEC: state_s = RESP;
            RESP: begin
                if (rsp_hs_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register and request latch; illegal ops present ADD to the ULA
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            gidx_r       <= 1'b0;
            srca_r       <= {W{1'b0}};
            srcb_r       <= {W{1'b0}};
            ctrl_r       <= ULA_ADD;
            illegal_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                last_grant_r <= gnt_idx_s;
                gidx_r       <= gnt_idx_s;
                srca_r       <= sel_a_s;
                srcb_r       <= sel_b_s;
                ctrl_r       <= ula_op_legal(sel_op_s) ? sel_op_s : ULA_ADD;
                illegal_r    <= !ula_op_legal(sel_op_s);
            end
        end
    end

    // Response capture at the end of EXEC; fields then hold until the next EXEC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_r <= {W{1'b0}};
            zero_r   <= 1'b0;
            err_r    <= 1'b0;
        end else if (state_r == EXEC) begin
            if (illegal_r) begin
                result_r <= {W{1'b0}};
                zero_r   <= 1'b1;
                err_r    <= 1'b1;
            end else begin
                result_r <= ula_result;
                zero_r   <= ula_flagz;
                err_r    <= 1'b0;
            end
        end
    end

endmodule
